// File: rtl/dtw_pkg.sv
// dtw_pkg: shared constants, PE source-select codes and sequencer states for the DTW array
package dtw_pkg;
    localparam int N_PE = 6;
    localparam int IW = 5;
    localparam int band_w = 3;
    localparam logic [1:0] SRC_HOLD = 2'b00;
    localparam logic [1:0] SRC_EXT = 2'b01;
    localparam logic [1:0] SRC_SHIFT = 2'b10;
    typedef enum logic [2:0] {IDLE, LOADR, RUN, BEND, DONE} state_t;
    function automatic logic [N_PE-1:0] band_mask(input logic [5:0] base, input logic [5:0] len);
        logic [N_PE-1:0] m;
        for (int k = 0; k < N_PE; k++)
            m[k] = base + 6'(N_PE - 1 - k) < len;
        return m;
    endfunction
endpackage

// File: rtl/dtw_skew_mask.sv
// dtw_skew_mask: diagonal-skew activity and T source selects for each PE at stream step c
module dtw_skew_mask
    import dtw_pkg::*;
(
    input  logic [5:0]        c,
    input  logic [5:0]        t_len,
    output logic [N_PE-1:0]   active,
    output logic [2*N_PE-1:0] tsrc
);
    genvar k;
    generate
        for (k = 0; k < N_PE; k++) begin : g_pe
            localparam logic [5:0] LAG = 6'(N_PE - 1 - k);
            assign active[k] = (c >= LAG) && (c - LAG < t_len);
            assign tsrc[2*N_PE-1-2*k -: 2] = !active[k] ? SRC_HOLD : (k == N_PE - 1 ? SRC_EXT : SRC_SHIFT);
        end
    endgenerate
endmodule

// File: rtl/dtw_sched.sv
// dtw_sched: band/skew sequencer driving the 6-PE DTW systolic array
module dtw_sched
    import dtw_pkg::*;
(
    input  logic                clk,
    input  logic                nrst,
    input  logic                start,
    input  logic [5:0]          t_len,
    input  logic [5:0]          r_len,
    input  logic                stall,
    output logic                arr_ena,
    output logic [IW-1:0]       o_tindex,
    output logic [IW-1:0]       o_rindex,
    output logic [2*N_PE-1:0]   o_tsrc,
    output logic [2*N_PE-1:0]   o_rsrc,
    output logic [N_PE-1:0]     row_mask,
    output logic [N_PE-1:0]     path_vld,
    output logic [band_w-1:0]   band,
    output logic                busy,
    output logic                done,
    output logic                err
);
    state_t state, state_n;
    logic [5:0] c, c_n, tl, rl, b, bc;
    logic [band_w-1:0] band_n;
    logic [N_PE-1:0] active;
    logic [2*N_PE-1:0] tsrc;
    logic run_last, last_band;
    assign b = 6'(band) * 6'd6;
    assign bc = b + c;
    assign run_last = {1'b0, c} == {1'b0, tl} + 7'd4;
    assign last_band = {1'b0, b} + 7'd6 >= {1'b0, rl};
    dtw_skew_mask u_skew (
        .c      (c),
        .t_len  (tl),
        .active (active),
        .tsrc   (tsrc)
    );
    always_comb begin
        state_n = state;
        c_n = c;
        band_n = band;
        case (state)
            IDLE: if (start) begin
                state_n = (t_len == '0 || r_len == '0) ? DONE : LOADR;
                c_n = '0;
                band_n = '0;
            end
            LOADR: if (!stall) begin
                state_n = c == 6'(N_PE - 1) ? RUN : LOADR;
                c_n = c == 6'(N_PE - 1) ? '0 : c + 6'd1;
            end
            RUN: if (!stall) begin
                state_n = run_last ? BEND : RUN;
                c_n = run_last ? '0 : c + 6'd1;
            end
            BEND: begin
                state_n = last_band ? DONE : LOADR;
                band_n = last_band ? band : band + band_w'(1);
            end
            default: begin
                state_n = IDLE;
                band_n = '0;
            end
        endcase
    end
    // row_mask is captured once on entry to each band's preload and held through RUN/BEND
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            state <= IDLE;
            c <= '0;
            band <= '0;
            tl <= '0;
            rl <= '0;
            row_mask <= '0;
            path_vld <= '0;
        end else begin
            state <= state_n;
            c <= c_n;
            band <= band_n;
            if (state == IDLE && start) begin
                tl <= t_len;
                rl <= r_len;
            end
            if (state_n == LOADR && state != LOADR)
                row_mask <= band_mask(6'(band_n) * 6'd6, state == IDLE ? r_len : rl);
            else if (state == DONE)
                row_mask <= '0;
            path_vld <= (state == RUN && !stall) ? active & row_mask : '0;
        end
    assign arr_ena = (state == LOADR || state == RUN) && !stall;
    assign o_tindex = (state == RUN && c < tl) ? c[IW-1:0] : '0;
    assign o_rindex = (state == LOADR && bc < rl) ? bc[IW-1:0] : '0;
    assign o_rsrc = state == LOADR ? {SRC_EXT, {(N_PE - 1){SRC_SHIFT}}} : '0;
    assign o_tsrc = state == RUN ? tsrc : '0;
    assign busy = state != IDLE;
    assign done = state == DONE;
    assign err = done && (tl == '0 || rl == '0);
endmodule

// File: tb/tb_dtw_sched.sv
// tb_dtw_sched: directed and randomized checks of dtw_sched against a per-cycle job trace model
module tb_dtw_sched;
    logic clk = 1'b0;
    logic nrst, start, stall, arr_ena, busy, done, err;
    logic [5:0] t_len, r_len, row_mask, path_vld;
    logic [4:0] o_tindex, o_rindex;
    logic [11:0] o_tsrc, o_rsrc;
    logic [2:0] band;
    int n_chk = 0;
    int n_fail = 0;
    int cur = 0;

    always #5 clk = ~clk;

    dtw_sched dut (
        .clk      (clk),
        .nrst     (nrst),
        .start    (start),
        .t_len    (t_len),
        .r_len    (r_len),
        .stall    (stall),
        .arr_ena  (arr_ena),
        .o_tindex (o_tindex),
        .o_rindex (o_rindex),
        .o_tsrc   (o_tsrc),
        .o_rsrc   (o_rsrc),
        .row_mask (row_mask),
        .path_vld (path_vld),
        .band     (band),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    typedef struct packed {
        logic        arr;
        logic        run;
        logic        busy;
        logic        done;
        logic        err;
        logic        chk_bm;
        logic [4:0]  tidx;
        logic [4:0]  ridx;
        logic [11:0] tsrc;
        logic [11:0] rsrc;
        logic [5:0]  mask;
        logic [5:0]  act;
        logic [2:0]  band;
    } step_t;

    step_t q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s step %0d: observed %0h expected %0h", tag, cur, obs, exp);
        end
    endtask

    // Expected cycle-by-cycle trace of one unstalled job, derived from the band/preload/stream rules
    task automatic build(input int t, input int r);
        step_t s;
        q.delete();
        if (t == 0 || r == 0) begin
            s = '0;
            s.busy = 1'b1;
            s.done = 1'b1;
            s.err = 1'b1;
            q.push_back(s);
            return;
        end
        for (int bd = 0; bd * 6 < r; bd++) begin
            s = '0;
            s.busy = 1'b1;
            s.chk_bm = 1'b1;
            s.band = 3'(bd);
            for (int k = 0; k < 6; k++) s.mask[k] = (bd * 6 + 5 - k < r);
            s.arr = 1'b1;
            s.rsrc = 12'b01_10_10_10_10_10;
            for (int c = 0; c < 6; c++) begin
                s.ridx = (bd * 6 + c < r) ? 5'(bd * 6 + c) : 5'd0;
                q.push_back(s);
            end
            s.ridx = '0;
            s.rsrc = '0;
            s.run = 1'b1;
            for (int c = 0; c < t + 5; c++) begin
                s.tidx = (c < t) ? 5'(c) : 5'd0;
                s.tsrc = '0;
                for (int k = 0; k < 6; k++) begin
                    s.act[k] = (c - (5 - k) >= 0) && (c - (5 - k) < t);
                    if (s.act[k]) s.tsrc[11 - 2 * k -: 2] = (k == 5) ? 2'b01 : 2'b10;
                end
                q.push_back(s);
            end
            s.arr = 1'b0;
            s.run = 1'b0;
            s.tidx = '0;
            s.tsrc = '0;
            s.act = '0;
            q.push_back(s);
        end
        s = '0;
        s.busy = 1'b1;
        s.done = 1'b1;
        q.push_back(s);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".arr_ena"}, arr_ena, 0);
        chk({tag, ".tindex"}, o_tindex, 0);
        chk({tag, ".rindex"}, o_rindex, 0);
        chk({tag, ".tsrc"}, o_tsrc, 0);
        chk({tag, ".rsrc"}, o_rsrc, 0);
        chk({tag, ".row_mask"}, row_mask, 0);
        chk({tag, ".path_vld"}, path_vld, 0);
        chk({tag, ".band"}, band, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".err"}, err, 0);
    endtask

    // mode 0: clean run, 1: random stalls and start/length noise, 2: 3-cycle stall at RUN c=2
    task automatic run_job(input int t, input int r, input int mode, input int abort_at);
        int i, ncyc, nst, dir, exp_cyc;
        logic [5:0] pv;
        step_t s;
        i = 0;
        ncyc = 0;
        nst = 0;
        dir = 0;
        pv = '0;
        exp_cyc = (t == 0 || r == 0) ? 1 : ((r + 5) / 6) * (t + 12) + 1;
        build(t, r);
        @(posedge clk); #1;
        start = 1'b1;
        t_len = 6'(t);
        r_len = 6'(r);
        @(posedge clk); #1;
        start = 1'b0;
        while (i < q.size()) begin
            s = q[i];
            stall = 1'b0;
            if (s.arr && mode == 1 && $urandom_range(0, 7) == 0) stall = 1'b1;
            if (s.arr && mode == 2 && i == 8 && dir < 3) begin
                stall = 1'b1;
                dir++;
            end
            if (mode == 1) begin
                start = 1'($urandom_range(0, 1));
                t_len = 6'($urandom_range(0, 32));
                r_len = 6'($urandom_range(0, 32));
            end
            @(negedge clk);
            cur = i;
            chk("arr_ena", arr_ena, s.arr && !stall);
            chk("tindex", o_tindex, s.tidx);
            chk("rindex", o_rindex, s.ridx);
            chk("tsrc", o_tsrc, s.tsrc);
            chk("rsrc", o_rsrc, s.rsrc);
            chk("busy", busy, s.busy);
            chk("done", done, s.done);
            chk("err", err, s.err);
            chk("path_vld", path_vld, pv);
            if (s.chk_bm) begin
                chk("row_mask", row_mask, s.mask);
                chk("band", band, s.band);
            end
            ncyc++;
            if (i == abort_at) begin
                nrst = 1'b0;
                #1;
                chk_zero("abort");
                @(posedge clk); #1;
                nrst = 1'b1;
                stall = 1'b0;
                start = 1'b0;
                return;
            end
            pv = (s.run && !stall) ? (s.act & s.mask) : 6'd0;
            if (stall) nst++;
            else i++;
            @(posedge clk); #1;
        end
        stall = 1'b0;
        start = 1'b0;
        @(negedge clk);
        cur = -1;
        chk("idle.busy", busy, 0);
        chk("idle.done", done, 0);
        chk("idle.arr_ena", arr_ena, 0);
        chk("idle.path_vld", path_vld, pv);
        chk("idle.err", err, 0);
        chk("cycles", ncyc, exp_cyc + nst);
    endtask

    initial begin
        nrst = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        t_len = '0;
        r_len = '0;
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;
        nrst = 1'b1;
        run_job(4, 6, 0, -1);
        run_job(32, 32, 0, -1);
        run_job(4, 6, 2, -1);
        run_job(0, 6, 0, -1);
        run_job(5, 0, 0, -1);
        run_job(3, 12, 0, 26);
        run_job(1, 1, 0, -1);
        run_job(7, 13, 1, -1);
        repeat (8) run_job(int'($urandom_range(1, 32)), int'($urandom_range(1, 32)), 1, -1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
